// File: rtl/countdown_pkg.sv
// Shared types and helpers for the M:SS game-countdown sequencer.
package countdown_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    EXPIRED = 3'd4
  } cd_state_t;

  // Countdown reload value, BCD M:SS = 2:00
  localparam logic [11:0] LOAD_VALUE = 12'h200;

  // BCD M:SS to whole seconds; the largest encodable value 9:99 still fits in 10 bits
  function automatic logic [9:0] bcd_to_secs(input logic [11:0] bcd);
    return (10'(bcd[11:8]) * 10'd60) + (10'(bcd[7:4]) * 10'd10) + 10'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/countdown_ctrl_tick_prescaler.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while run is high and wraps to 0.
// With COUNTDOWN_WARN_EN it also flags the two half-second blink points.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 31_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
`ifdef COUNTDOWN_WARN_EN
  ,
  output logic blink_edge
`endif
);

  localparam int unsigned      CNT_W    = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

  // Decoded from the held count, so a paused count keeps its fractional second
  assign tick = (count == CNT_MAX);

`ifdef COUNTDOWN_WARN_EN
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICKS_PER_SEC / 2);

  assign blink_edge = (count == '0) || (count == CNT_HALF);
`endif

endmodule

// File: rtl/countdown_ctrl.sv
// Game-timer sequencer: load strobe, one-second decrement enable and start/pause/restart FSM.
// Optional COUNTDOWN_WARN_EN adds the cnt_value input and the blinking low-time warn output.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LOAD    | one cycle, cnt_load high, prescaler cleared
// RUNNING | prescaler advancing, cnt_ena once per second
// PAUSED  | prescaler frozen mid-second, no cnt_ena
// EXPIRED | count hit 0:00, only restart/reset leave
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 31_500_000
`ifdef COUNTDOWN_WARN_EN
  ,
  parameter int unsigned WARN_SECS = 10
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause_tog,
  input  logic restart,
  input  logic cnt_tc,
  output logic cnt_load,
  output logic cnt_ena,
  output logic running,
  output logic paused,
  output logic expired,
  output logic time_up
`ifdef COUNTDOWN_WARN_EN
  ,
  input  logic [11:0] cnt_value,
  output logic        warn
`endif
);

  cd_state_t state;
  cd_state_t state_nxt;
  logic      tick;
  logic      presc_clr;
  logic      presc_run;
`ifdef COUNTDOWN_WARN_EN
  logic      blink_edge;
  logic      warn_zone;
`endif

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_presc (
    .clk       (clk),
    .reset     (reset),
    .clr       (presc_clr),
    .run       (presc_run),
    .tick      (tick)
`ifdef COUNTDOWN_WARN_EN
    ,
    .blink_edge(blink_edge)
`endif
  );

  // A pause that lands on a tick still advances, so the prescaler wraps to 0 before freezing
  assign presc_clr = restart || (state == LOAD);
  assign presc_run = (state == RUNNING) && !restart && !cnt_tc && (!pause_tog || tick);

  assign cnt_ena = (state == RUNNING) && tick && !cnt_tc && !restart;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (restart || start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = restart ? LOAD : RUNNING;
      end
      RUNNING: begin
        if (restart)        state_nxt = LOAD;
        else if (cnt_tc)    state_nxt = EXPIRED;
        else if (pause_tog) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (restart)                 state_nxt = LOAD;
        else if (pause_tog || start) state_nxt = RUNNING;
      end
      EXPIRED: begin
        if (restart) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt_load <= 1'b0;
      running  <= 1'b0;
      paused   <= 1'b0;
      expired  <= 1'b0;
      time_up  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_load <= (state_nxt == LOAD);
      running  <= (state_nxt == RUNNING);
      paused   <= (state_nxt == PAUSED);
      expired  <= (state_nxt == EXPIRED);
      time_up  <= (state_nxt == EXPIRED) && (state != EXPIRED);
    end
  end

`ifdef COUNTDOWN_WARN_EN
  assign warn_zone = (bcd_to_secs(cnt_value) <= 10'(WARN_SECS));

  always_ff @(posedge clk) begin
    if (reset) begin
      warn <= 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          if (!warn_zone)      warn <= 1'b0;
          else if (blink_edge) warn <= ~warn;
        end
        PAUSED:  warn <= warn_zone;
        EXPIRED: warn <= 1'b1;
        default: warn <= 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl driving a behavioural BCD M:SS countdown datapath.
module tb_countdown_ctrl;
  import countdown_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause_tog = 1'b0;
  logic        restart = 1'b0;
  logic        cnt_tc;
  logic        cnt_load, cnt_ena, running, paused, expired, time_up;
  logic [11:0] val;
`ifdef COUNTDOWN_WARN_EN
  logic        warn;
  logic [7:0]  pat;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .TICKS_PER_SEC(4)
`ifdef COUNTDOWN_WARN_EN
    ,
    .WARN_SECS(10)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause_tog(pause_tog),
    .restart  (restart),
    .cnt_tc   (cnt_tc),
    .cnt_load (cnt_load),
    .cnt_ena  (cnt_ena),
    .running  (running),
    .paused   (paused),
    .expired  (expired),
    .time_up  (time_up)
`ifdef COUNTDOWN_WARN_EN
    ,
    .cnt_value(val),
    .warn     (warn)
`endif
  );

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd5;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)         val <= 12'h000;
    else if (cnt_load) val <= LOAD_VALUE;
    else if (cnt_ena)  val <= bcd_dec(val);
  end

  assign cnt_tc = (val == 12'h000);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    int ena_n;
    int tu_n;
    int bad;

    // 1: reset, then start
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_outs", 32'({cnt_load, cnt_ena, running, paused, expired, time_up}), 32'd0);
    reset = 1'b0;
    nxt(); start = 1'b1;
    nxt(); start = 1'b0;
    chk("load_pulse", 32'({cnt_load, running}), 32'b10);
    nxt();
    chk("run_after_load", 32'({cnt_load, running}), 32'b01);
    chk("val_loaded", 32'(val), 32'h200);
    for (int k = 1; k <= 3; k++) begin
      nxt();
      chk("first_ena", 32'(cnt_ena), (k == 3) ? 1 : 0);
    end
    nxt();
    chk("val_159", 32'(val), 32'h159);

    // 2: run down to 0:00
    ena_n = 0; bad = 0; n = 0;
    while (expired !== 1'b1 && n < 2000) begin
      if (cnt_ena) ena_n++;
      if (cnt_ena && cnt_tc) bad++;
      nxt();
      n++;
    end
    chk("expired", 32'(expired), 1);
    chk("time_up_entry", 32'(time_up), 1);
    chk("ena_to_zero", ena_n, 119);
    chk("val_zero", 32'(val), 0);
    tu_n = 0;
    for (int k = 0; k < 20; k++) begin
      start     = (k == 3);
      pause_tog = (k == 7);
      nxt();
      if (time_up) tu_n++;
      if (cnt_ena) bad++;
      if (val !== 12'h000 || expired !== 1'b1) bad++;
    end
    start = 1'b0; pause_tog = 1'b0;
    chk("hold_zero", bad, 0);
    chk("time_up_once", tu_n, 0);

    // 4b: restart from EXPIRED
    restart = 1'b1;
    nxt(); restart = 1'b0;
    chk("restart_exp_load", 32'({cnt_load, expired}), 32'b10);
    nxt();
    chk("restart_exp_run", 32'({running, val}), 32'({1'b1, 12'h200}));

    // 3: pause at prescaler 2, resume
    nxt(); nxt();
    pause_tog = 1'b1; #1;
    chk("pause_no_ena", 32'(cnt_ena), 0);
    nxt(); pause_tog = 1'b0;
    chk("paused", 32'({running, paused}), 32'b01);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (cnt_ena || !paused) n++;
      nxt();
    end
    chk("paused_quiet", n, 0);
    chk("val_paused", 32'(val), 32'h200);
    pause_tog = 1'b1;
    nxt(); pause_tog = 1'b0;
    chk("resume_t1", 32'({running, cnt_ena}), 32'b10);
    nxt();
    chk("resume_t2_ena", 32'(cnt_ena), 1);
    nxt();
    chk("val_after_resume", 32'(val), 32'h159);

    // 4a: restart while RUNNING at 1:37
    n = 0;
    while (val !== 12'h137 && n < 2000) begin
      nxt();
      n++;
    end
    chk("reach_137", 32'(val), 32'h137);
    restart = 1'b1; #1;
    chk("restart_run_noena", 32'(cnt_ena), 0);
    nxt(); restart = 1'b0;
    chk("restart_run_load", 32'({cnt_load, running}), 32'b10);
    nxt();
    chk("restart_run_200", 32'({running, val}), 32'({1'b1, 12'h200}));

    // 5: restart on tick, then pause on tick
    nxt(); nxt(); nxt();
    restart = 1'b1; #1;
    chk("tick_restart_ena", 32'(cnt_ena), 0);
    nxt(); restart = 1'b0;
    chk("tick_restart_load", 32'(cnt_load), 1);
    nxt();
    chk("tick_restart_200", 32'(val), 32'h200);
    nxt(); nxt(); nxt();
    pause_tog = 1'b1; #1;
    chk("tick_pause_ena", 32'(cnt_ena), 1);
    nxt(); pause_tog = 1'b0;
    chk("tick_pause_state", 32'({paused, val}), 32'({1'b1, 12'h159}));
    chk("tick_pause_presc", 32'(dut.u_presc.count), 0);
    start = 1'b1;
    nxt(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("start_resume_ena", 32'(cnt_ena), (k == 4) ? 1 : 0);
      if (k < 4) nxt();
    end
    nxt();

`ifdef COUNTDOWN_WARN_EN
    // 6: warn threshold, blink and pause
    n = 0;
    while (val !== 12'h011 && n < 3000) begin
      nxt();
      n++;
    end
    chk("reach_011", 32'(val), 32'h011);
    for (int k = 0; k < 4; k++) begin
      chk("warn_011", 32'(warn), 0);
      nxt();
    end
    chk("val_010", 32'(val), 32'h010);
    pat = 8'b0110_0110;
    for (int k = 0; k < 8; k++) begin
      chk("warn_blink", 32'(warn), 32'(pat[k]));
      nxt();
    end
    pause_tog = 1'b1;
    nxt(); pause_tog = 1'b0;
    nxt();
    for (int k = 0; k < 5; k++) begin
      chk("warn_paused", 32'(warn), 1);
      nxt();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
